// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-ported, variable-latency memory between the core's
//   instruction fetch (F) and data access (M). Data has fixed priority over fetch.
// Latency: an access is accepted in IDLE, holds mem_req until mem_ready, and delivers its
//   result in the following DONE cycle. There is always one bubble (IDLE) between accesses.
// Backpressure: istall/dstall hold the requesting stage until its DONE cycle. The memory
//   side has no backpressure: mem_ready is a one-cycle completion pulse.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   PCF, IReqF           fetch address / level fetch request
//   InstrF, istall       fetched instruction / fetch-not-complete
//   ALUOutM, WriteDataM  data address / store data
//   MemWriteM, MemtoRegM store / load request (both set = store)
//   ReadDataM, dstall    load data / data-access-not-complete
//   mem_*                memory port (mem_rdata valid with mem_ready)
//   starve_cnt           saturating count of cycles fetch was blocked by data
// Option: define ARB_FETCH_BUF_EN for a one-entry fetch buffer that serves repeated
//   fetches of the last fetched address without a memory access.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] PCF,
  input  logic              IReqF,
  output logic [DATA_W-1:0] InstrF,
  output logic              istall,
  input  logic [ADDR_W-1:0] ALUOutM,
  input  logic [DATA_W-1:0] WriteDataM,
  input  logic              MemWriteM,
  input  logic              MemtoRegM,
  output logic [DATA_W-1:0] ReadDataM,
  output logic              dstall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  starve_cnt
);

  typedef enum logic [2:0] {IDLE, DBUSY, DDONE, IBUSY, IDONE} state_t;

  state_t            state;
  state_t            nextState;
  logic              dreq;
  logic              fetchHit;
  logic [DATA_W-1:0] hitInstr;
  logic [ADDR_W-1:0] reqAddr;
  logic [DATA_W-1:0] reqWdata;
  logic              reqWe;
  logic [DATA_W-1:0] instrReg;
  logic [DATA_W-1:0] readReg;
  logic [CNT_W-1:0]  starveReg;
  logic              starveNow;

  assign dreq = MemWriteM | MemtoRegM;

`ifdef ARB_FETCH_BUF_EN
  logic              bufValid;
  logic [ADDR_W-1:0] bufTag;
  logic [DATA_W-1:0] bufInstr;

  // A hit is only taken where a normal fetch would be accepted, so data still wins.
  assign fetchHit = (state == IDLE) && !dreq && IReqF && bufValid && (bufTag == PCF);
  assign hitInstr = bufInstr;

  always_ff @(posedge clk) begin
    if (reset) begin
      bufValid <= 1'b0;
      bufTag   <= '0;
      bufInstr <= '0;
    end else if (state == IDONE) begin
      bufValid <= 1'b1;
      bufTag   <= reqAddr;
      bufInstr <= instrReg;
    end else if ((state == DDONE) && reqWe && (reqAddr == bufTag)) begin
      // A store to the buffered address makes the cached instruction stale.
      bufValid <= 1'b0;
    end
  end
`else
  assign fetchHit = 1'b0;
  assign hitInstr = '0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Next-state logic; mem_ready is only meaningful in the BUSY states.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (dreq)                     nextState = DBUSY;
        else if (IReqF && !fetchHit)  nextState = IBUSY;
      end
      DBUSY:   if (mem_ready) nextState = DDONE;
      DDONE:   nextState = IDLE;
      IBUSY:   if (mem_ready) nextState = IDONE;
      IDONE:   nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    mem_req = (state == DBUSY) || (state == IBUSY);
    mem_we  = mem_req && reqWe;
    dstall  = dreq && (state != DDONE);
    // A withdrawn fetch still completes, but istall follows IReqF so it reads 0.
    istall  = IReqF && (state != IDONE) && !fetchHit;
    InstrF  = fetchHit ? hitInstr : instrReg;
  end

  assign mem_addr   = reqAddr;
  assign mem_wdata  = reqWdata;
  assign ReadDataM  = readReg;
  assign starve_cnt = starveReg;

  // Fetch counts as starved while a data access owns the port, including the
  // IDLE cycle where data wins the arbitration.
  assign starveNow = IReqF && ((state == DBUSY) || (state == DDONE) ||
                               ((state == IDLE) && dreq));

  // Request register, result registers and starvation counter
  always_ff @(posedge clk) begin
    if (reset) begin
      reqAddr   <= '0;
      reqWdata  <= '0;
      reqWe     <= 1'b0;
      instrReg  <= '0;
      readReg   <= '0;
      starveReg <= '0;
    end else begin
      if (state == IDLE) begin
        if (dreq) begin
          reqAddr  <= ALUOutM;
          reqWdata <= WriteDataM;
          reqWe    <= MemWriteM;
        end else if (IReqF && !fetchHit) begin
          reqAddr <= PCF;
          reqWe   <= 1'b0;
        end
      end
      if ((state == DBUSY) && mem_ready && !reqWe) readReg <= mem_rdata;
      if ((state == IBUSY) && mem_ready)           instrReg <= mem_rdata;
      if (starveNow && (starveReg != {CNT_W{1'b1}}))
        starveReg <= starveReg + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: randomized self-checking bench for mem_port_arbiter against a
//   transaction-level model (access = accept cycle, N busy cycles, one done cycle).
// Latency/backpressure: the bench plays both the core and the memory.
module tb_mem_port_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int CW   = 6;
  localparam int CMAX = (1 << CW) - 1;
`ifdef ARB_FETCH_BUF_EN
  localparam bit BUF_ON = 1'b1;
`else
  localparam bit BUF_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] PCF;
  logic          IReqF;
  logic [DW-1:0] InstrF;
  logic          istall;
  logic [AW-1:0] ALUOutM;
  logic [DW-1:0] WriteDataM;
  logic          MemWriteM;
  logic          MemtoRegM;
  logic [DW-1:0] ReadDataM;
  logic          dstall;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic [CW-1:0] starve_cnt;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .PCF(PCF), .IReqF(IReqF), .InstrF(InstrF), .istall(istall),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
    .ReadDataM(ReadDataM), .dstall(dstall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .starve_cnt(starve_cnt)
  );

  int          checkCount = 0;
  int          failCount  = 0;
  int          expStarve  = 0;
  logic [31:0] expRead    = '0;
  logic [31:0] expInstr   = '0;
  bit          bufValid   = 1'b0;
  logic [31:0] bufTag     = '0;
  logic [31:0] bufData    = '0;

  task automatic expectEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic beginCycle();
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    mem_rdata = $urandom;
  endtask

  task automatic endCycle(input bit starved);
    expectEq("starve_cnt", 32'(starve_cnt), 32'(expStarve));
    if (starved && expStarve < CMAX) expStarve++;
  endtask

  task automatic doIdle();
    beginCycle();
    MemWriteM = 1'b0; MemtoRegM = 1'b0; IReqF = 1'b0;
    PCF = $urandom; ALUOutM = $urandom; mem_ready = 1'($urandom % 2);
    @(negedge clk);
    expectEq("idle.mem_req", 32'(mem_req), 0);
    expectEq("idle.istall", 32'(istall), 0);
    expectEq("idle.dstall", 32'(dstall), 0);
    expectEq("idle.ReadDataM", ReadDataM, expRead);
    expectEq("idle.InstrF", InstrF, expInstr);
    endCycle(1'b0);
  endtask

  // One data access of 'lat' busy cycles; optionally a fetch is requested alongside it.
  task automatic doData(input bit isStore, input logic [31:0] addr, input logic [31:0] wdata,
                        input int lat, input bit withFetch, input logic [31:0] pc,
                        input logic [31:0] rd);
    beginCycle();
    MemWriteM = isStore;
    MemtoRegM = isStore ? 1'($urandom % 2) : 1'b1;
    ALUOutM = addr; WriteDataM = wdata; IReqF = withFetch; PCF = pc;
    mem_ready = 1'($urandom % 2);
    @(negedge clk);
    expectEq("dacc.mem_req", 32'(mem_req), 0);
    expectEq("dacc.dstall", 32'(dstall), 1);
    expectEq("dacc.istall", 32'(istall), 32'(withFetch));
    endCycle(withFetch);
    for (int i = 1; i <= lat; i++) begin
      beginCycle();
      ALUOutM = $urandom; WriteDataM = $urandom;
      mem_ready = (i == lat);
      if (i == lat) mem_rdata = rd;
      @(negedge clk);
      expectEq("dbusy.mem_req", 32'(mem_req), 1);
      expectEq("dbusy.mem_we", 32'(mem_we), 32'(isStore));
      expectEq("dbusy.mem_addr", mem_addr, addr);
      if (isStore) expectEq("dbusy.mem_wdata", mem_wdata, wdata);
      expectEq("dbusy.dstall", 32'(dstall), 1);
      expectEq("dbusy.istall", 32'(istall), 32'(withFetch));
      endCycle(withFetch);
    end
    if (!isStore) expRead = rd;
    beginCycle();
    mem_ready = 1'($urandom % 2);
    @(negedge clk);
    expectEq("ddone.mem_req", 32'(mem_req), 0);
    expectEq("ddone.dstall", 32'(dstall), 0);
    expectEq("ddone.istall", 32'(istall), 32'(withFetch));
    expectEq("ddone.ReadDataM", ReadDataM, expRead);
    endCycle(withFetch);
    if (isStore && bufValid && bufTag == addr) bufValid = 1'b0;
  endtask

  // One fetch; withdrawAt>0 drops IReqF from that busy cycle onwards.
  task automatic doFetch(input logic [31:0] pc, input int lat, input int withdrawAt,
                         input logic [31:0] rd);
    bit hit;
    bit reqOn;
    beginCycle();
    MemWriteM = 1'b0; MemtoRegM = 1'b0; IReqF = 1'b1; PCF = pc; ALUOutM = $urandom;
    mem_ready = 1'($urandom % 2);
    hit = BUF_ON && bufValid && (bufTag == pc);
    @(negedge clk);
    expectEq("facc.mem_req", 32'(mem_req), 0);
    expectEq("facc.dstall", 32'(dstall), 0);
    expectEq("facc.istall", 32'(istall), 32'(!hit));
    if (hit) expectEq("fhit.InstrF", InstrF, bufData);
    endCycle(1'b0);
    if (hit) return;
    reqOn = 1'b1;
    for (int i = 1; i <= lat; i++) begin
      beginCycle();
      if (withdrawAt != 0 && i >= withdrawAt) reqOn = 1'b0;
      IReqF = reqOn; PCF = $urandom;
      mem_ready = (i == lat);
      if (i == lat) mem_rdata = rd;
      @(negedge clk);
      expectEq("fbusy.mem_req", 32'(mem_req), 1);
      expectEq("fbusy.mem_we", 32'(mem_we), 0);
      expectEq("fbusy.mem_addr", mem_addr, pc);
      expectEq("fbusy.istall", 32'(istall), 32'(reqOn));
      expectEq("fbusy.InstrF", InstrF, expInstr);
      endCycle(1'b0);
    end
    expInstr = rd;
    beginCycle();
    mem_ready = 1'($urandom % 2);
    @(negedge clk);
    expectEq("fdone.mem_req", 32'(mem_req), 0);
    expectEq("fdone.istall", 32'(istall), 0);
    expectEq("fdone.InstrF", InstrF, expInstr);
    endCycle(1'b0);
    if (BUF_ON) begin
      bufValid = 1'b1; bufTag = pc; bufData = rd;
    end
  endtask

  // Load with a pending fetch, reset in the middle of the access, then a stray mem_ready.
  task automatic doResetMid();
    beginCycle();
    MemWriteM = 1'b0; MemtoRegM = 1'b1; ALUOutM = 32'h2000; IReqF = 1'b1; PCF = 32'h10C;
    @(negedge clk);
    endCycle(1'b1);
    beginCycle();
    @(negedge clk);
    expectEq("rst.busy.mem_req", 32'(mem_req), 1);
    endCycle(1'b1);
    beginCycle();
    reset = 1'b1;
    @(negedge clk);
    expectEq("rst.dstall", 32'(dstall), 1);
    expectEq("rst.istall", 32'(istall), 1);
    expectEq("rst.starve_before", 32'(starve_cnt), 32'(expStarve));
    expStarve = 0; expRead = '0; expInstr = '0; bufValid = 1'b0;
    beginCycle();
    reset = 1'b0; MemtoRegM = 1'b0; IReqF = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    expectEq("rst.mem_req", 32'(mem_req), 0);
    expectEq("rst.mem_we", 32'(mem_we), 0);
    expectEq("rst.mem_addr", mem_addr, 0);
    expectEq("rst.mem_wdata", mem_wdata, 0);
    expectEq("rst.ReadDataM", ReadDataM, 0);
    expectEq("rst.InstrF", InstrF, 0);
    endCycle(1'b0);
    doIdle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          r;
    int          lat;
    logic [31:0] pc;
    logic [31:0] rd;

    reset = 1'b1; IReqF = 1'b1; MemtoRegM = 1'b1; MemWriteM = 1'b0;
    PCF = '0; ALUOutM = '0; WriteDataM = '0; mem_ready = 1'b0; mem_rdata = '0;
    beginCycle();
    beginCycle();
    @(negedge clk);
    expectEq("reset.dstall", 32'(dstall), 1);
    expectEq("reset.istall", 32'(istall), 1);
    expectEq("reset.mem_req", 32'(mem_req), 0);
    expectEq("reset.mem_addr", mem_addr, 0);
    expectEq("reset.InstrF", InstrF, 0);
    expectEq("reset.ReadDataM", ReadDataM, 0);
    expectEq("reset.starve", 32'(starve_cnt), 0);
    beginCycle();
    reset = 1'b0; IReqF = 1'b0; MemtoRegM = 1'b0;
    @(negedge clk);
    endCycle(1'b0);

    // Directed scenarios
    doFetch(32'h100, 3, 0, 32'hE3A01005);
    doData(1'b0, 32'h2000, 32'h0, 2, 1'b1, 32'h104, 32'h12345678);
    doFetch(32'h104, 2, 0, 32'hA5A50104);
    expectEq("conflict.starve", 32'(starve_cnt), 4);
    doData(1'b1, 32'h40, 32'hDEADBEEF, 3, 1'b0, 32'h0, 32'h0BADF00D);
    doIdle();
    doResetMid();
    doFetch(32'h100, 2, 0, 32'hE3A01005);
    doFetch(32'h108, 4, 2, 32'h11110108);
    doIdle();
    doIdle();
    doFetch(32'h100, 2, 0, 32'h22220100);
    doFetch(32'h100, 2, 0, 32'h33330100);
    doData(1'b1, 32'h100, 32'h44440100, 1, 1'b0, 32'h0, 32'h0);
    doFetch(32'h100, 2, 0, 32'h55550100);
    // Long data access with a waiting fetch drives the counter into saturation.
    doData(1'b0, 32'h3000, 32'h0, 70, 1'b1, 32'h10C, 32'h66663000);
    expectEq("sat.starve", 32'(starve_cnt), CMAX);
    doFetch(32'h10C, 1, 0, 32'h7777010C);
    doIdle();

    for (int n = 0; n < 300; n++) begin
      r   = $urandom_range(0, 11);
      lat = $urandom_range(1, 5);
      pc  = 32'h100 + 32'(4 * $urandom_range(0, 3));
      rd  = $urandom;
      case (r)
        0, 1:    doIdle();
        2, 3, 4: doFetch(pc, lat, 0, rd);
        5, 6:    doData(1'b0, $urandom, $urandom, lat, 1'b0, pc, rd);
        7:       doData(1'b1, ($urandom % 2) ? pc : $urandom, $urandom, lat, 1'b0, pc, rd);
        8, 9: begin
          doData(1'($urandom % 2), $urandom, $urandom, lat, 1'b1, pc, rd);
          doFetch(pc, $urandom_range(1, 5), 0, $urandom);
        end
        10:      doFetch(pc, lat, $urandom_range(1, lat), rd);
        default: if (n % 4 == 0) doResetMid(); else doIdle();
      endcase
    end
    doIdle();

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency memory between the pipelined core's instruction fetch (F stage) and data access (M stage).
- Sequences each access with a small FSM and returns results to the core.
- Generates the istall/dstall signals consumed by the hazard unit.
- Data accesses have fixed priority over fetch. A cycle counter records fetch starvation.

Parameters:
- ADDR_W, 32, address width of PCF, ALUOutM and mem_addr.
- DATA_W, 32, data width of all data/instruction buses.
- CNT_W, 16, width of the fetch-starvation counter.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- PCF  input  ADDR_W  fetch address
- IReqF  input  1  fetch request, level, held until istall low
- InstrF  output  DATA_W  fetched instruction, valid when IReqF & ~istall
- istall  output  1  fetch not yet complete
- ALUOutM  input  ADDR_W  data address
- WriteDataM  input  DATA_W  store data
- MemWriteM  input  1  store request
- MemtoRegM  input  1  load request
- ReadDataM  output  DATA_W  load data, valid when MemtoRegM & ~dstall
- dstall  output  1  data access not yet complete
- mem_req  output  1  memory access strobe
- mem_we  output  1  write enable, qualified by mem_req
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data, valid with mem_ready
- mem_ready  input  1  one-cycle completion pulse, arrives ≥1 cycle after mem_req rises
- starve_cnt  output  CNT_W  cycles fetch was blocked by a data access

Behaviour:
- dreq = MemWriteM | MemtoRegM. If both are set, the access is treated as a store.
- FSM states: IDLE, DBUSY, DDONE, IBUSY, IDONE. Reset → IDLE.
- IDLE:
  - If dreq: latch ALUOutM, WriteDataM and MemWriteM into the request register, go to DBUSY.
  - Else if IReqF: latch PCF, go to IBUSY.
  - Else stay in IDLE.
- DBUSY/IBUSY:
  - mem_req=1; mem_addr, mem_we and mem_wdata come from the request register and are stable for the whole access.
  - On mem_ready: capture mem_rdata (DBUSY → ReadDataM register, IBUSY → InstrF register), go to DDONE/IDONE.
- DDONE/IDONE: mem_req=0; one-cycle delivery; return to IDLE. The next access starts no earlier than the following IDLE cycle, so there is one bubble between accesses.
- dstall = dreq & (state != DDONE). It deasserts only in the DDONE cycle.
- istall = IReqF & (state != IDONE). It deasserts only in the IDONE cycle.
- mem_ready outside DBUSY/IBUSY is ignored.
- Fetch withdrawn during IBUSY (IReqF drops, e.g. flush):
  - The access completes normally.
  - InstrF is updated, but istall stays 0 because IReqF=0.
  - The FSM passes through IDONE to IDLE.
- Stores: ReadDataM is not updated. DDONE is still a one-cycle state.
- Simultaneous dreq and IReqF in IDLE: data wins. Fetch waits for the following IDLE cycle.
- starve_cnt increments by 1 each cycle that IReqF=1 and state is DBUSY or DDONE, or state is IDLE with dreq=1. It saturates at all-ones and never wraps.
- Reset in any state (including mid-access):
  - Next state IDLE.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - InstrF=0, ReadDataM=0, starve_cnt=0.
  - A pending mem_ready arriving after reset is ignored.
- Reset values of the derived outputs: dstall=dreq and istall=IReqF while reset is held. State is IDLE, not a DONE state, so the pipeline stays frozen.

Optional Feature:
- Macro ARB_FETCH_BUF_EN.
- When defined: a one-entry fetch buffer (valid bit, PCF tag, instruction) is filled at each IDONE.
  - In IDLE with no dreq, IReqF=1 and a tag hit, InstrF comes from the buffer and istall=0 in that same cycle. No memory access is made and the FSM stays in IDLE.
  - A hit has the same priority as a normal fetch, so it is never taken while dreq=1.
  - A store whose address equals the tag clears valid at its DDONE.
  - Reset clears valid.
- When undefined: no buffer. Every fetch goes through IBUSY/IDONE.

Test Plan:
- Fetch only:
  - Stimulus: IReqF=1, PCF=0x100, mem_ready pulsed 3 cycles after mem_req rises with mem_rdata=0xE3A01005.
  - Response: mem_req high 3 cycles with mem_addr=0x100; istall low exactly one cycle, with InstrF=0xE3A01005.
- Load vs fetch conflict:
  - Stimulus: MemtoRegM=1, ALUOutM=0x2000 and IReqF=1 (PCF=0x104) in the same IDLE cycle, mem_ready after 2 cycles.
  - Response: data access issues first; ReadDataM = mem_rdata at DDONE; the fetch of 0x104 starts 2 cycles later; starve_cnt=4.
- Store:
  - Stimulus: MemWriteM=1, ALUOutM=0x40, WriteDataM=0xDEADBEEF.
  - Response: mem_we=1, mem_wdata=0xDEADBEEF for the whole access; dstall drops at DDONE; ReadDataM unchanged.
- Reset during DBUSY:
  - Stimulus: assert reset for 1 cycle, then pulse mem_ready.
  - Response: mem_req=0 the cycle after reset; the stray mem_ready is ignored; starve_cnt=0; the next fetch proceeds normally.
- Flush mid-fetch:
  - Stimulus: drop IReqF during IBUSY.
  - Response: istall=0 immediately; the FSM completes to IDLE within one cycle of mem_ready; no spurious second access.
- With ARB_FETCH_BUF_EN defined:
  - Refetching 0x100 with no intervening store: istall=0, mem_req stays 0.
  - After a store to 0x100: the refetch goes through IBUSY.
